// File: rtl/mem_access_unit_pkg.sv
// Shared types for the data-memory load/store sequencer: size codes, FSM states
// and the size/alignment helpers.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Size code 2'b11 is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = addr_lo[0];
      default:   is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and byte-wide memory port of the load/store sequencer.
// master: the sequencer; slave: pipeline plus memory side.
interface mem_access_unit_if #(
  parameter int ADDR_W = 9
);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic              ReqSE;
  logic [1:0]        ReqSize;
  logic [ADDR_W-1:0] ReqAddress;
  logic [31:0]       ReqData;
  logic              RespValid;
  logic [31:0]       RespData;
  logic              RespErr;
  logic              MemEnable;
  logic              MemReadWrite;
  logic [ADDR_W-1:0] MemAddress;
  logic [7:0]        MemDataOut;
  logic [7:0]        MemDataIn;

  modport master (
    input  ReqValid, ReqWrite, ReqSE, ReqSize, ReqAddress, ReqData, MemDataIn,
    output ReqReady, RespValid, RespData, RespErr,
           MemEnable, MemReadWrite, MemAddress, MemDataOut
  );

  modport slave (
    output ReqValid, ReqWrite, ReqSE, ReqSize, ReqAddress, ReqData, MemDataIn,
    input  ReqReady, RespValid, RespData, RespErr,
           MemEnable, MemReadWrite, MemAddress, MemDataOut
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Load-data extension: right-justified big-endian accumulator to a 32-bit result,
// zero- or sign-extended by access size.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] acc,
  input  logic [1:0]  size,
  input  logic        se,
  output logic [31:0] result
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
    result = acc;
    case (size)
      SIZE_BYTE: result = {(se ? {24{acc[7]}}  : 24'b0), acc[7:0]};
      SIZE_HALF: result = {(se ? {16{acc[15]}} : 16'b0), acc[15:0]};
      default:   result = acc;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: one request becomes 1/2/4 byte beats, MSB first.
// Optional `define ALIGN_CHECK_EN faults misaligned halfword/word accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int MEM_WAIT = 0
) (
  input logic                Clk,
  input logic                Reset,
  mem_access_unit_if.master  bus
);

  localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  state_t            state_q, state_d;
  logic              write_q;
  logic              se_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic [1:0]        last_q;
  logic [1:0]        beat_q;
  logic [WAIT_W-1:0] wait_q;
  logic [31:0]       acc_q;
  logic              err_q;

  logic              accept;
  logic              misalign;
  logic              beat_end;
  logic [2:0]        nbytes;
  logic [1:0]        sel_idx;
  logic [31:0]       ext;

  load_extend u_ext (
    .acc    (acc_q),
    .size   (size_q),
    .se     (se_q),
    .result (ext)
  );

`ifdef ALIGN_CHECK_EN
  assign misalign = is_misaligned(bus.ReqSize, bus.ReqAddress[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign nbytes   = size_bytes(bus.ReqSize) - 3'd1;
  assign beat_end = (wait_q == WAIT_W'(MEM_WAIT));
  // Beat k carries byte (N-1-k) of the store data, counted from the LSB.
  assign sel_idx  = last_q - beat_q;

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    bus.ReqReady     = 1'b0;
    bus.RespValid    = 1'b0;
    bus.RespData     = '0;
    bus.RespErr      = 1'b0;
    bus.MemEnable    = 1'b0;
    bus.MemReadWrite = 1'b0;
    bus.MemAddress   = '0;
    bus.MemDataOut   = '0;
    case (state_q)
      IDLE: begin
        bus.ReqReady = 1'b1;
        if (bus.ReqValid) begin
          accept  = 1'b1;
          state_d = misalign ? DONE : XFER;
        end
      end
      XFER: begin
        bus.MemEnable    = 1'b1;
        bus.MemReadWrite = write_q;
        bus.MemAddress   = addr_q + ADDR_W'(beat_q);
        bus.MemDataOut   = write_q ? data_q[{sel_idx, 3'b000} +: 8] : 8'h00;
        if (beat_end && (beat_q == last_q)) state_d = DONE;
      end
      DONE: begin
        bus.RespValid = 1'b1;
        bus.RespData  = (write_q || err_q) ? 32'h0 : ext;
`ifdef ALIGN_CHECK_EN
        bus.RespErr   = err_q;
`endif
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (Reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      se_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q <= bus.ReqWrite;
            se_q    <= bus.ReqSE;
            size_q  <= bus.ReqSize;
            addr_q  <= bus.ReqAddress;
            data_q  <= bus.ReqData;
            last_q  <= nbytes[1:0];
            beat_q  <= '0;
            wait_q  <= '0;
            acc_q   <= '0;
            err_q   <= misalign;
          end
        end
        XFER: begin
          if (beat_end) begin
            wait_q <= '0;
            beat_q <= beat_q + 2'd1;
            if (!write_q) acc_q <= {acc_q[23:0], bus.MemDataIn};
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: MEM_WAIT=0 instance for functional cases,
// MEM_WAIT=2 instance for beat stretching and request holding.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int ADDR_W = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rv0, rv1;
  logic        r_write, r_se;
  logic [1:0]  r_size;
  logic [8:0]  r_addr;
  logic [31:0] r_data;
  logic        pk0, pk1;
  logic [8:0]  pk_addr;
  logic [7:0]  pk_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem0 [512];
  logic [7:0] mem1 [512];
  logic [8:0] wlog_a [$];
  logic [7:0] wlog_d [$];
  logic [8:0] trace1 [$];
  int resp_cnt0 = 0;
  int en_cnt0   = 0;
  int acc_cnt1  = 0;

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus0 ();
  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus1 ();

  assign bus0.ReqValid   = rv0;
  assign bus0.ReqWrite   = r_write;
  assign bus0.ReqSE      = r_se;
  assign bus0.ReqSize    = r_size;
  assign bus0.ReqAddress = r_addr;
  assign bus0.ReqData    = r_data;
  assign bus0.MemDataIn  = mem0[bus0.MemAddress];

  assign bus1.ReqValid   = rv1;
  assign bus1.ReqWrite   = r_write;
  assign bus1.ReqSE      = r_se;
  assign bus1.ReqSize    = r_size;
  assign bus1.ReqAddress = r_addr;
  assign bus1.ReqData    = r_data;
  assign bus1.MemDataIn  = mem1[bus1.MemAddress];

  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_WAIT(0)) u_dut0 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus0)
  );

  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_WAIT(2)) u_dut1 (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus1)
  );

  // Memory models: writes land at the edge that ends each write cycle.
  always @(posedge clk) begin
    if (pk0) mem0[pk_addr] <= pk_data;
    else if (bus0.MemEnable && bus0.MemReadWrite) begin
      mem0[bus0.MemAddress] <= bus0.MemDataOut;
      wlog_a.push_back(bus0.MemAddress);
      wlog_d.push_back(bus0.MemDataOut);
    end
    if (bus0.RespValid) resp_cnt0 <= resp_cnt0 + 1;
    if (bus0.MemEnable) en_cnt0 <= en_cnt0 + 1;
  end

  always @(posedge clk) begin
    if (pk1) mem1[pk_addr] <= pk_data;
    else if (bus1.MemEnable && bus1.MemReadWrite) mem1[bus1.MemAddress] <= bus1.MemDataOut;
    if (bus1.ReqValid && bus1.ReqReady) acc_cnt1 <= acc_cnt1 + 1;
    if (bus1.MemEnable) trace1.push_back(bus1.MemAddress);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int sel, input logic [8:0] a, input logic [7:0] d);
    pk_addr = a;
    pk_data = d;
    if (sel == 0) pk0 = 1'b1; else pk1 = 1'b1;
    @(posedge clk);
    #1;
    pk0 = 1'b0;
    pk1 = 1'b0;
  endtask

  // Issue one request; lat = edges from the accept edge to the edge sampling RespValid.
  task automatic run_req(input int sel, input logic w, input logic se, input logic [1:0] sz,
                         input logic [8:0] a, input logic [31:0] d, input bit hold,
                         output int lat, output logic [31:0] rdata, output logic rerr);
    int   n;
    logic rdy;
    logic rv;
    r_write = w;
    r_se    = se;
    r_size  = sz;
    r_addr  = a;
    r_data  = d;
    if (sel == 0) rv0 = 1'b1; else rv1 = 1'b1;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = (sel == 0) ? bus0.ReqReady : bus1.ReqReady;
      @(posedge clk);
      n++;
    end
    check($sformatf("accept_%0d_%h", sel, a), {31'b0, rdy}, 32'd1);
    #1;
    if (!hold) begin
      rv0 = 1'b0;
      rv1 = 1'b0;
    end
    lat   = 0;
    rv    = 1'b0;
    rdata = '0;
    rerr  = 1'b0;
    while (!rv && lat < 60) begin
      @(negedge clk);
      rv = (sel == 0) ? bus0.RespValid : bus1.RespValid;
      if (rv) begin
        rdata = (sel == 0) ? bus0.RespData : bus1.RespData;
        rerr  = (sel == 0) ? bus0.RespErr  : bus1.RespErr;
      end
      @(posedge clk);
      lat++;
    end
    if (!rv) lat = -1;
    #1;
  endtask

  initial begin
    int          lat;
    int          base;
    logic [31:0] rd;
    logic        re;
    logic        rv;
    int          n;

    rst = 1'b1; rv0 = 1'b0; rv1 = 1'b0; pk0 = 1'b0; pk1 = 1'b0;
    r_write = 1'b0; r_se = 1'b0; r_size = 2'b00; r_addr = '0; r_data = '0;
    pk_addr = '0; pk_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready",  {31'b0, bus0.ReqReady},     32'd1);
    check("rst_rvalid", {31'b0, bus0.RespValid},    32'd0);
    check("rst_rdata",  bus0.RespData,              32'd0);
    check("rst_rerr",   {31'b0, bus0.RespErr},      32'd0);
    check("rst_men",    {31'b0, bus0.MemEnable},    32'd0);
    check("rst_mrw",    {31'b0, bus0.MemReadWrite}, 32'd0);
    check("rst_maddr",  {23'b0, bus0.MemAddress},   32'd0);
    check("rst_mdout",  {24'b0, bus0.MemDataOut},   32'd0);

    // Reset after two beats of a word store.
    for (int i = 0; i < 4; i++) poke(0, 9'h010 + 9'(i), 8'h55);
    base    = resp_cnt0;
    r_write = 1'b1; r_se = 1'b0; r_size = SIZE_WORD; r_addr = 9'h010; r_data = 32'hA1B2C3D4;
    rv0 = 1'b1;
    @(posedge clk);
    #1 rv0 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_ready", {31'b0, bus0.ReqReady},  32'd1);
    check("abort_men",   {31'b0, bus0.MemEnable}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_noresp", resp_cnt0, base);
    check("abort_m10", {24'b0, mem0[9'h010]}, 32'hA1);
    check("abort_m11", {24'b0, mem0[9'h011]}, 32'hB2);
    check("abort_m12", {24'b0, mem0[9'h012]}, 32'h55);
    check("abort_m13", {24'b0, mem0[9'h013]}, 32'h55);

    // Word store then word load at 0x010.
    wlog_a.delete();
    wlog_d.delete();
    run_req(0, 1'b1, 1'b0, SIZE_WORD, 9'h010, 32'hDEADBEEF, 1'b0, lat, rd, re);
    check("st_w_lat",   lat, 32'd5);
    check("st_w_rdata", rd, 32'd0);
    check("st_w_nlog",  wlog_a.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] word;
      word = 32'hDEADBEEF;
      check($sformatf("st_w_addr%0d", i), {23'b0, wlog_a[i]}, 32'h010 + i);
      check($sformatf("st_w_byte%0d", i), {24'b0, wlog_d[i]}, {24'b0, word[31-8*i -: 8]});
    end
    run_req(0, 1'b0, 1'b0, SIZE_WORD, 9'h010, 32'h0, 1'b0, lat, rd, re);
    check("ld_w_lat",   lat, 32'd5);
    check("ld_w_rdata", rd, 32'hDEADBEEF);
    check("ld_w_rerr",  {31'b0, re}, 32'd0);

    // Byte loads with and without sign extension.
    poke(0, 9'h020, 8'h80);
    run_req(0, 1'b0, 1'b1, SIZE_BYTE, 9'h020, 32'h0, 1'b0, lat, rd, re);
    check("ld_b_se_lat", lat, 32'd2);
    check("ld_b_se",     rd, 32'hFFFFFF80);
    run_req(0, 1'b0, 1'b0, SIZE_BYTE, 9'h020, 32'h0, 1'b0, lat, rd, re);
    check("ld_b_ze",     rd, 32'h00000080);

    // Halfword sign extension, positive and negative.
    poke(0, 9'h030, 8'h7F);
    poke(0, 9'h031, 8'hFF);
    run_req(0, 1'b0, 1'b1, SIZE_HALF, 9'h030, 32'h0, 1'b0, lat, rd, re);
    check("ld_h_lat", lat, 32'd3);
    check("ld_h_pos", rd, 32'h00007FFF);
    poke(0, 9'h030, 8'h80);
    poke(0, 9'h031, 8'h01);
    run_req(0, 1'b0, 1'b1, SIZE_HALF, 9'h030, 32'h0, 1'b0, lat, rd, re);
    check("ld_h_neg", rd, 32'hFFFF8001);
    run_req(0, 1'b0, 1'b0, SIZE_HALF, 9'h030, 32'h0, 1'b0, lat, rd, re);
    check("ld_h_ze",  rd, 32'h00008001);

    // Misaligned word across the top of the address space.
    poke(0, 9'h1FE, 8'hEE);
    poke(0, 9'h1FF, 8'hEE);
    poke(0, 9'h000, 8'hEE);
    poke(0, 9'h001, 8'hEE);
    base = en_cnt0;
    run_req(0, 1'b1, 1'b0, SIZE_WORD, 9'h1FE, 32'h01020304, 1'b0, lat, rd, re);
`ifdef ALIGN_CHECK_EN
    check("wrap_err",   {31'b0, re}, 32'd1);
    check("wrap_rdata", rd, 32'd0);
    check("wrap_lat",   lat, 32'd1);
    check("wrap_noen",  en_cnt0, base);
    check("wrap_m1fe",  {24'b0, mem0[9'h1FE]}, 32'hEE);
    check("wrap_m000",  {24'b0, mem0[9'h000]}, 32'hEE);
`else
    check("wrap_err",   {31'b0, re}, 32'd0);
    check("wrap_lat",   lat, 32'd5);
    check("wrap_en",    en_cnt0 - base, 32'd4);
    check("wrap_m1fe",  {24'b0, mem0[9'h1FE]}, 32'h01);
    check("wrap_m1ff",  {24'b0, mem0[9'h1FF]}, 32'h02);
    check("wrap_m000",  {24'b0, mem0[9'h000]}, 32'h03);
    check("wrap_m001",  {24'b0, mem0[9'h001]}, 32'h04);
    run_req(0, 1'b0, 1'b0, SIZE_WORD, 9'h1FE, 32'h0, 1'b0, lat, rd, re);
    check("wrap_load",  rd, 32'h01020304);
`endif

    // Byte store writes only the low byte; size 11 loads like a word.
    poke(0, 9'h040, 8'h00);
    wlog_a.delete();
    wlog_d.delete();
    run_req(0, 1'b1, 1'b0, SIZE_BYTE, 9'h040, 32'h123456AB, 1'b0, lat, rd, re);
    check("st_b_nlog", wlog_a.size(), 32'd1);
    check("st_b_m40",  {24'b0, mem0[9'h040]}, 32'hAB);
    run_req(0, 1'b0, 1'b1, 2'b11, 9'h010, 32'h0, 1'b0, lat, rd, re);
    check("ld_sz3_lat", lat, 32'd5);
    check("ld_sz3",     rd, 32'hDEADBEEF);

    // MEM_WAIT=2 halfword load with the request held throughout.
    poke(1, 9'h050, 8'h9A);
    poke(1, 9'h051, 8'hBC);
    trace1.delete();
    run_req(1, 1'b0, 1'b0, SIZE_HALF, 9'h050, 32'h0, 1'b1, lat, rd, re);
    check("w2_lat",    lat, 32'd7);
    check("w2_rdata",  rd, 32'h00009ABC);
    check("w2_ntrace", trace1.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("w2_addr%0d", i), {23'b0, trace1[i]}, (i < 3) ? 32'h050 : 32'h051);
    check("w2_hold_once", acc_cnt1, 32'd1);
    check("w2_ready",     {31'b0, bus1.ReqReady}, 32'd1);
    @(posedge clk);
    #1 rv1 = 1'b0;
    check("w2_reaccept", acc_cnt1, 32'd2);
    n  = 0;
    rv = 1'b0;
    rd = '0;
    while (!rv && n < 30) begin
      @(negedge clk);
      rv = bus1.RespValid;
      if (rv) rd = bus1.RespData;
      @(posedge clk);
      n++;
    end
    check("w2_second_lat",   n, 32'd7);
    check("w2_second_rdata", rd, 32'h00009ABC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
